ami_axi_arbiter: RTL and testbench
==================================

# ami_axi_arbiter

Shares one `axi_bus_t` master port between `NUM_PORTS` legacy AMI requesters, each with one read and one write channel. Reads and writes are arbitrated independently, round-robin, and registered onto AXI as single-beat 64-byte bursts. The AXI ID carries the requester index, so read data returns to the issuing port. The block sits between several `DNNDrive_SoftReg`-class engines and the virtual memory interface, replacing the one-app AMI emulation glue.

## Interface
Parameters:
- `NUM_PORTS`, 4: requester count, 2..8.
- `MAX_RD_OUT`, 16: maximum outstanding reads per port, 1..255.

Ports:
- `clk`  in  1: the single clock for the block.
- `rst`  in  1: synchronous, active-low reset.
- `rd_reqs`  in  AMIRequest[NUM_PORTS]: read requests; `isWrite`, `data` and `size` are ignored.
- `rd_req_grants`  out  1[NUM_PORTS]: read request accepted this cycle.
- `rd_resps`  out  AMIResponse[NUM_PORTS]: read data; `size` is fixed at 64.
- `rd_resp_grants`  in  1[NUM_PORTS]: requester accepts read data.
- `wr_reqs`  in  AMIRequest[NUM_PORTS]: write requests; `addr[5:0]` is 0 and `size` is 64.
- `wr_req_grants`  out  1[NUM_PORTS]: write request accepted this cycle.
- `axi_m`  master  axi_bus_t: shared memory port.
- `idle`  out  1: no reads outstanding and both issue slots empty.

## Operation
- **Fixed AXI fields:**
  - `arlen`/`awlen` = 0.
  - `arsize`/`awsize` = 3'b110.
  - `wstrb` = all ones.
  - `wlast` = 1.
  - `bready` = 1.
  - `rresp` and `bresp` are ignored.
- **Read issue slot (AR register):**
  - The slot loads when it is empty, or when `arvalid && arready` in the same cycle.
  - Winner = first eligible port, searching from `rd_ptr` upward with wrap.
  - Eligible = `rd_reqs[i].valid` and `rd_cnt[i] < MAX_RD_OUT`.
  - On load: `rd_req_grants[winner]`=1 in that same cycle, `araddr`=addr, `arid`=winner, `arvalid`=1 next cycle, `rd_ptr` = (winner+1) mod NUM_PORTS.
  - `rd_ptr` does not move when no port is granted.
- **Read return path (combinational):**
  - `rd_resps[rid].valid` = `rvalid`, with `data` = `rdata`.
  - Every other port sees valid=0.
  - `rready` = `rd_resp_grants[rid]`.
- **Per-port outstanding counters:**
  - `rd_cnt[i]` increments on read grant for port i.
  - It decrements on `rvalid && rready && rid==i`.
  - Both events in the same cycle: the count is unchanged.
  - A port at `MAX_RD_OUT` receives no grant until a response drains.
- **Write issue slot (W register):**
  - Holds `awaddr`, `wdata`, `awid`=winner, and flags `aw_pend` and `w_pend`.
  - `awvalid`=`aw_pend`, `wvalid`=`w_pend`.
  - Each flag clears independently on its own handshake, so AW and W are never coupled combinationally.
  - The slot loads when both flags are clear, or are clearing this cycle.
  - On load, both flags are set and the round-robin uses `wr_ptr`, with the same rules as reads.
- `idle` = all `rd_cnt`==0, `arvalid`==0, `aw_pend`==0 and `w_pend`==0.
- **Reset:**
  - All valid outputs, flags and counters go to 0.
  - `rd_ptr`=`wr_ptr`=0.
  - `idle`=1.
  - Reset mid-operation discards in-flight transactions.
  - Responses that arrive after reset are dropped: `rready`=0 while `rst` is low.

## Timing
- Grant to `arvalid`/`awvalid`: 1 cycle.
- Sustained throughput is one read and one write per cycle when `arready`, `awready` and `wready` are held high.
- `rready`/`rresp` path: zero latency, combinational through `rid`.
- AW accepted before W, or W before AW: the slot holds the remaining half. No new write is granted until both halves are accepted.
- Read grant and read return for the same port in one cycle: the counter is unchanged and the port stays eligible.

## Configuration
- `AMI_ARB_FIXED_PRIO_EN` defined:
  - Both arbiters use fixed priority, with the lowest eligible index winning.
  - `rd_ptr` and `wr_ptr` are removed.
- Undefined: round-robin as described above.

## Structure
- **Shared package `AMITypes`:**
  - `AMIRequest` and `AMIResponse` (existing).
  - New constant `AMI_BLOCK_BYTES`=64.
  - New typedef `ami_port_idx_t` (width `$clog2(NUM_PORTS)`, minimum 1).
- **Sub-module `rr_arbiter`:**
  - Parameterized by N.
  - Inputs: request vector, `advance`.
  - Outputs: one-hot grant, index.
  - Holds the pointer and the macro switch.
  - Instantiated twice, for read and for write.

## Test plan
- **Single read:** port 2 reads 0x1000.
  - Expect `arid`=2 and `araddr`=0x1000 one cycle after grant.
  - `rvalid` with `rid`=2 must appear only on `rd_resps[2]`, and `idle` returns to 1.
- **Read fairness:** all four ports request continuously with `arready`=1.
  - Expect `arid` order 0,1,2,3,0,… with one grant per cycle.
- **Read credit limit:** `MAX_RD_OUT`=2, port 0 issues 3 reads with no responses.
  - Expect the third grant only after one response is accepted.
- **Split write handshake:** `awready`=1 and `wready`=0 for 3 cycles.
  - Expect `awvalid` to drop after one cycle, `wvalid` to be held, and no second `wr_req_grant` until `wready`.
- **Back-pressure:** `rd_resp_grants[1]`=0 while `rvalid` has `rid`=1.
  - Expect `rready`=0, data held, and the counter unchanged.
- **Mid-burst reset:** drive `rst` low with 3 reads outstanding.
  - The next cycle must show all valids 0 and `idle`=1.

Source files
------------

// File: rtl/AMITypes.sv
// ---------------------------------------------------------------------------
// AMITypes: types and constants shared by the AMI requesters, the AXI
// arbiter and the AXI bus interface.
//   AMIRequest      : valid / isWrite / addr / data / size request record
//   AMIResponse     : valid / data / size response record
//   AMI_BLOCK_BYTES : size of one AMI transfer (one AXI beat)
//   ami_port_idx_t  : requester index for the default port count
//   port_idx_w()    : index width for an N-port arbiter, minimum 1 bit
// ---------------------------------------------------------------------------
package AMITypes;

  localparam int AMI_ADDR_W      = 64;
  localparam int AMI_DATA_W      = 512;
  localparam int AMI_BLOCK_BYTES = 64;
  localparam int AMI_NUM_PORTS   = 4;
  // Wide enough to carry any requester index up to the 8-port maximum.
  localparam int AXI_ID_W        = 3;

  typedef struct packed {
    logic                  valid;
    logic                  isWrite;
    logic [AMI_ADDR_W-1:0] addr;
    logic [AMI_DATA_W-1:0] data;
    logic [63:0]           size;
  } AMIRequest;

  typedef struct packed {
    logic                  valid;
    logic [AMI_DATA_W-1:0] data;
    logic [63:0]           size;
  } AMIResponse;

  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AMI_PORT_IDX_W = (AMI_NUM_PORTS > 1) ? $clog2(AMI_NUM_PORTS) : 1;
  typedef logic [AMI_PORT_IDX_W-1:0] ami_port_idx_t;

endpackage

// File: rtl/axi_bus_t.sv
// ---------------------------------------------------------------------------
// axi_bus_t: AXI4 bus carrying single-beat 64-byte transfers.
//   master modport : drives AW/W/AR and bready/rready, samples the rest
//   slave  modport : the memory side
// ---------------------------------------------------------------------------
interface axi_bus_t;

  logic                              awvalid;
  logic                              awready;
  logic [AMITypes::AMI_ADDR_W-1:0]   awaddr;
  logic [AMITypes::AXI_ID_W-1:0]     awid;
  logic [7:0]                        awlen;
  logic [2:0]                        awsize;

  logic                              wvalid;
  logic                              wready;
  logic [AMITypes::AMI_DATA_W-1:0]   wdata;
  logic [AMITypes::AMI_DATA_W/8-1:0] wstrb;
  logic                              wlast;

  logic                              bvalid;
  logic                              bready;
  logic [AMITypes::AXI_ID_W-1:0]     bid;
  logic [1:0]                        bresp;

  logic                              arvalid;
  logic                              arready;
  logic [AMITypes::AMI_ADDR_W-1:0]   araddr;
  logic [AMITypes::AXI_ID_W-1:0]     arid;
  logic [7:0]                        arlen;
  logic [2:0]                        arsize;

  logic                              rvalid;
  logic                              rready;
  logic [AMITypes::AMI_DATA_W-1:0]   rdata;
  logic [AMITypes::AXI_ID_W-1:0]     rid;
  logic [1:0]                        rresp;
  logic                              rlast;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready,
    output arvalid, araddr, arid, arlen, arsize, input arready,
    input  rvalid, rdata, rid, rresp, rlast, output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input  arvalid, araddr, arid, arlen, arsize, output arready,
    output rvalid, rdata, rid, rresp, rlast, input rready
  );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter: N-way arbiter with a one-hot grant and a binary index.
// Default build is round-robin: the search starts at the pointer and wraps;
// the pointer moves to winner+1 only when 'advance' is high and some
// request was present. With AMI_ARB_FIXED_PRIO_EN defined the lowest
// requesting index always wins and there is no pointer state.
//   clk, rst : clock, synchronous active-low reset
//   req      : request vector
//   advance  : the consumer takes the current winner this cycle
//   grant    : one-hot winner (all zero when no request)
//   idx      : binary winner index
// ---------------------------------------------------------------------------
module rr_arbiter
  import AMITypes::*;
#(
  parameter  int N  = 4,
  localparam int IW = port_idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

`ifdef AMI_ARB_FIXED_PRIO_EN

  logic unused_ok;
  assign unused_ok = ^{clk, rst, advance};

  always_comb begin
    grant = '0;
    idx   = '0;
    // Walk downward so the lowest requesting index is the last to write.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

`else

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[wrap_add(ptr_q, k)]) begin
        found = 1'b1;
        idx   = wrap_add(ptr_q, k);
      end
    end
    if (found) grant[idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) ptr_d = wrap_add(idx, 1);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

`endif

endmodule

// File: rtl/ami_axi_arbiter.sv
// ---------------------------------------------------------------------------
// ami_axi_arbiter: shares one AXI master between NUM_PORTS AMI requesters.
// Reads and writes are arbitrated independently and registered onto AXI as
// single-beat 64-byte bursts. The requester index travels in the AXI ID so
// read data is steered back to the issuing port without any lookup table.
// Build option: AMI_ARB_FIXED_PRIO_EN selects fixed (lowest index) priority
// in both arbiters instead of round-robin.
//   clk, rst        : clock, synchronous active-low reset
//   rd_reqs         : per-port read requests (addr and valid used)
//   rd_req_grants   : per-port read request accepted this cycle
//   rd_resps        : per-port read data, size fixed at 64
//   rd_resp_grants  : per-port read data accepted by the requester
//   wr_reqs         : per-port write requests (addr, data, valid used)
//   wr_req_grants   : per-port write request accepted this cycle
//   axi_m           : shared AXI master port
//   idle            : no reads outstanding and both issue slots empty
// ---------------------------------------------------------------------------
module ami_axi_arbiter
  import AMITypes::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int MAX_RD_OUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  AMIRequest            rd_reqs        [NUM_PORTS],
  output logic [NUM_PORTS-1:0] rd_req_grants,
  output AMIResponse           rd_resps       [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] rd_resp_grants,
  input  AMIRequest            wr_reqs        [NUM_PORTS],
  output logic [NUM_PORTS-1:0] wr_req_grants,
  axi_bus_t.master             axi_m,
  output logic                 idle
);

  localparam int IW = port_idx_w(NUM_PORTS);
  localparam int CW = $clog2(MAX_RD_OUT + 1);
  localparam logic [CW-1:0] RD_LIMIT = CW'(MAX_RD_OUT);

  logic [NUM_PORTS-1:0]  rd_elig, rd_win, rid_match;
  logic [NUM_PORTS-1:0]  wr_elig, wr_win;
  logic [IW-1:0]         rd_idx, wr_idx;
  logic                  ar_load, w_load, r_fire;

  logic                  arvalid_q, arvalid_d;
  logic [AMI_ADDR_W-1:0] araddr_q, araddr_d;
  logic [IW-1:0]         arid_q, arid_d;

  logic                  aw_pend_q, aw_pend_d;
  logic                  w_pend_q, w_pend_d;
  logic [AMI_ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [AMI_DATA_W-1:0] wdata_q, wdata_d;
  logic [IW-1:0]         awid_q, awid_d;

  logic [CW-1:0]         rd_cnt_q [NUM_PORTS];
  logic [CW-1:0]         rd_cnt_d [NUM_PORTS];

  // ---- eligibility and slot-load conditions -------------------------------
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      rd_elig[i]   = rd_reqs[i].valid && (rd_cnt_q[i] < RD_LIMIT);
      wr_elig[i]   = wr_reqs[i].valid;
      rid_match[i] = (axi_m.rid == AXI_ID_W'(i));
    end
  end

  // Holding rst low blocks all loads, so nothing is granted during reset.
  assign ar_load = rst && (!arvalid_q || axi_m.arready);
  // AW and W are tracked separately; a new write waits for both halves.
  assign w_load  = rst && (!aw_pend_q || axi_m.awready) && (!w_pend_q || axi_m.wready);

  assign rd_req_grants = ar_load ? rd_win : '0;
  assign wr_req_grants = w_load  ? wr_win : '0;

  rr_arbiter #(.N(NUM_PORTS)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_elig),
    .advance (ar_load),
    .grant   (rd_win),
    .idx     (rd_idx)
  );

  rr_arbiter #(.N(NUM_PORTS)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_elig),
    .advance (w_load),
    .grant   (wr_win),
    .idx     (wr_idx)
  );

  // ---- read issue slot ----------------------------------------------------
  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arid_d    = arid_q;
    if (ar_load) begin
      arvalid_d = |rd_elig;
      if (|rd_elig) begin
        araddr_d = rd_reqs[rd_idx].addr;
        arid_d   = rd_idx;
      end
    end
  end

  // ---- read return path: steer by rid, no storage -------------------------
  assign axi_m.rready = rst && |(rd_resp_grants & rid_match);
  assign r_fire       = axi_m.rvalid && axi_m.rready;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      rd_resps[i].valid = rst && axi_m.rvalid && rid_match[i];
      rd_resps[i].data  = axi_m.rdata;
      rd_resps[i].size  = 64'(AMI_BLOCK_BYTES);
    end
  end

  // ---- outstanding-read credit counters -----------------------------------
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      rd_cnt_d[i] = rd_cnt_q[i];
      // A grant and a return in the same cycle cancel out.
      if (rd_req_grants[i] && !(r_fire && rid_match[i]))
        rd_cnt_d[i] = rd_cnt_q[i] + CW'(1);
      else if (!rd_req_grants[i] && r_fire && rid_match[i])
        rd_cnt_d[i] = rd_cnt_q[i] - CW'(1);
    end
  end

  // ---- write issue slot ---------------------------------------------------
  always_comb begin
    aw_pend_d = aw_pend_q && !axi_m.awready;
    w_pend_d  = w_pend_q  && !axi_m.wready;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awid_d    = awid_q;
    if (w_load && |wr_elig) begin
      aw_pend_d = 1'b1;
      w_pend_d  = 1'b1;
      awaddr_d  = wr_reqs[wr_idx].addr;
      wdata_d   = wr_reqs[wr_idx].data;
      awid_d    = wr_idx;
    end
  end

  // ---- state --------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      arvalid_q <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) rd_cnt_q[i] <= '0;
    end else begin
      arvalid_q <= arvalid_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      for (int i = 0; i < NUM_PORTS; i++) rd_cnt_q[i] <= rd_cnt_d[i];
    end
  end

  // NOTE: address/data/ID payload registers carry no reset; they are only
  // observed while their valid flag is set, and skipping reset keeps the
  // wide data path free of reset fan-out.
  always_ff @(posedge clk) begin
    araddr_q <= araddr_d;
    arid_q   <= arid_d;
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    awid_q   <= awid_d;
  end

  // ---- AXI outputs --------------------------------------------------------
  assign axi_m.arvalid = arvalid_q;
  assign axi_m.araddr  = araddr_q;
  assign axi_m.arid    = AXI_ID_W'(arid_q);
  assign axi_m.arlen   = 8'd0;
  assign axi_m.arsize  = 3'b110;

  assign axi_m.awvalid = aw_pend_q;
  assign axi_m.awaddr  = awaddr_q;
  assign axi_m.awid    = AXI_ID_W'(awid_q);
  assign axi_m.awlen   = 8'd0;
  assign axi_m.awsize  = 3'b110;

  assign axi_m.wvalid  = w_pend_q;
  assign axi_m.wdata   = wdata_q;
  assign axi_m.wstrb   = '1;
  assign axi_m.wlast   = 1'b1;
  assign axi_m.bready  = 1'b1;

  always_comb begin
    idle = !arvalid_q && !aw_pend_q && !w_pend_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rd_cnt_q[i] != '0) idle = 1'b0;
    end
  end

  // Request fields and response status that this block deliberately ignores.
  logic unused_bits;
  always_comb begin
    unused_bits = ^{axi_m.rresp, axi_m.rlast, axi_m.bvalid, axi_m.bid, axi_m.bresp};
    for (int i = 0; i < NUM_PORTS; i++) begin
      unused_bits = unused_bits ^ (^{rd_reqs[i].isWrite, rd_reqs[i].data, rd_reqs[i].size,
                                     wr_reqs[i].isWrite, wr_reqs[i].size});
    end
  end

endmodule

// File: tb/tb_ami_axi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ami_axi_arbiter: directed self-checking bench for ami_axi_arbiter with
// four ports and a two-read credit limit per port.
// ---------------------------------------------------------------------------
module tb_ami_axi_arbiter;
  import AMITypes::*;

  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  AMIRequest       rd_reqs  [NP];
  AMIRequest       wr_reqs  [NP];
  AMIResponse      rd_resps [NP];
  logic [NP-1:0]   rd_req_grants, wr_req_grants, rd_resp_grants;
  logic            idle;

  axi_bus_t axi ();

  ami_axi_arbiter #(.NUM_PORTS(NP), .MAX_RD_OUT(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .rd_reqs        (rd_reqs),
    .rd_req_grants  (rd_req_grants),
    .rd_resps       (rd_resps),
    .rd_resp_grants (rd_resp_grants),
    .wr_reqs        (wr_reqs),
    .wr_req_grants  (wr_req_grants),
    .axi_m          (axi),
    .idle           (idle)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NP; i++) begin
      rd_reqs[i] = '0;
      wr_reqs[i] = '0;
    end
    rd_resp_grants = '0;
    axi.arready = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rid     = '0;
    axi.rresp   = '0;
    axi.rlast   = 1'b1;
    axi.bvalid  = 1'b0;
    axi.bid     = '0;
    axi.bresp   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NP-1:0] exp_oh;

    // ---- reset state and fixed AXI fields ----
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    axi.rvalid = 1'b1;
    axi.rid = 3'd0;
    rd_resp_grants = 4'b0001;
    rd_reqs[1].valid = 1'b1;
    #1;
    check("rst_idle", idle, 1'b1);
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_awvalid", axi.awvalid, 1'b0);
    check("rst_wvalid", axi.wvalid, 1'b0);
    check("rst_rready", axi.rready, 1'b0);
    check("rst_resp_valid", rd_resps[0].valid, 1'b0);
    check("rst_rd_grant", rd_req_grants, 4'b0000);
    check("fix_arlen", axi.arlen, 8'd0);
    check("fix_arsize", axi.arsize, 3'b110);
    check("fix_awsize", axi.awsize, 3'b110);
    check("fix_wstrb", axi.wstrb, {64{1'b1}});
    check("fix_wlast", axi.wlast, 1'b1);
    check("fix_bready", axi.bready, 1'b1);
    clear_inputs();
    rst = 1'b1;

    // ---- single read from port 2 ----
    rd_reqs[2].valid = 1'b1;
    rd_reqs[2].addr  = 64'h1000;
    #1;
    check("t1_grant", rd_req_grants, 4'b0100);
    tick();
    rd_reqs[2].valid = 1'b0;
    #1;
    check("t1_arvalid", axi.arvalid, 1'b1);
    check("t1_arid", axi.arid, 3'd2);
    check("t1_araddr", axi.araddr, 64'h1000);
    check("t1_busy", idle, 1'b0);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    #1;
    check("t1_ar_drained", axi.arvalid, 1'b0);
    axi.rvalid = 1'b1;
    axi.rid    = 3'd2;
    axi.rdata  = 512'hCAFE_0002;
    rd_resp_grants = 4'b0100;
    #1;
    check("t1_resp2_valid", rd_resps[2].valid, 1'b1);
    check("t1_resp2_data", rd_resps[2].data, 512'hCAFE_0002);
    check("t1_resp2_size", rd_resps[2].size, 64'd64);
    check("t1_resp0_valid", rd_resps[0].valid, 1'b0);
    check("t1_resp1_valid", rd_resps[1].valid, 1'b0);
    check("t1_resp3_valid", rd_resps[3].valid, 1'b0);
    check("t1_rready", axi.rready, 1'b1);
    tick();
    axi.rvalid = 1'b0;
    rd_resp_grants = '0;
    #1;
    check("t1_idle", idle, 1'b1);

    // ---- back-pressure on port 1 ----
    rd_reqs[1].valid = 1'b1;
    rd_reqs[1].addr  = 64'h2040;
    #1;
    check("bp_grant", rd_req_grants, 4'b0010);
    tick();
    rd_reqs[1].valid = 1'b0;
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1;
    axi.rid    = 3'd1;
    axi.rdata  = 512'hBEEF;
    #1;
    check("bp_rready_low", axi.rready, 1'b0);
    check("bp_resp_valid", rd_resps[1].valid, 1'b1);
    tick();
    check("bp_data_held", rd_resps[1].data, 512'hBEEF);
    check("bp_rready_still_low", axi.rready, 1'b0);
    check("bp_count_kept", idle, 1'b0);
    rd_resp_grants = 4'b0010;
    #1;
    check("bp_rready_high", axi.rready, 1'b1);
    tick();
    axi.rvalid = 1'b0;
    rd_resp_grants = '0;
    #1;
    check("bp_idle", idle, 1'b1);

    // ---- read fairness: 0,1,2,3,0,1,2,3 then credit stall ----
    do_reset();
    for (int i = 0; i < NP; i++) begin
      rd_reqs[i].valid = 1'b1;
      rd_reqs[i].addr  = 64'h100 * i;
    end
    axi.arready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_oh = 4'b0001 << (k % 4);
      check($sformatf("rr_grant_%0d", k), rd_req_grants, exp_oh);
      tick();
      check($sformatf("rr_arid_%0d", k), axi.arid, 3'(k % 4));
      check($sformatf("rr_araddr_%0d", k), axi.araddr, 64'h100 * (k % 4));
    end
    #1;
    check("rr_all_at_limit", rd_req_grants, 4'b0000);
    for (int i = 0; i < NP; i++) rd_reqs[i].valid = 1'b0;
    tick();
    check("rr_ar_drained", axi.arvalid, 1'b0);

    // ---- credit limit on port 0 ----
    do_reset();
    rd_reqs[0].valid = 1'b1;
    rd_reqs[0].addr  = 64'h3000;
    axi.arready = 1'b1;
    #1;
    check("cr_grant1", rd_req_grants, 4'b0001);
    tick();
    #1;
    check("cr_grant2", rd_req_grants, 4'b0001);
    tick();
    #1;
    check("cr_blocked_a", rd_req_grants, 4'b0000);
    tick();
    #1;
    check("cr_blocked_b", rd_req_grants, 4'b0000);
    axi.rvalid = 1'b1;
    axi.rid    = 3'd0;
    rd_resp_grants = 4'b0001;
    #1;
    check("cr_blocked_on_return", rd_req_grants, 4'b0000);
    check("cr_rready", axi.rready, 1'b1);
    tick();
    axi.rvalid = 1'b0;
    rd_resp_grants = '0;
    #1;
    check("cr_grant3", rd_req_grants, 4'b0001);
    tick();
    rd_reqs[0].valid = 1'b0;
    axi.rvalid = 1'b1;
    rd_resp_grants = 4'b0001;
    tick();
    tick();
    axi.rvalid = 1'b0;
    rd_resp_grants = '0;
    #1;
    check("cr_drained_idle", idle, 1'b1);

    // ---- grant and return for the same port in one cycle ----
    rd_reqs[0].valid = 1'b1;
    #1;
    check("sc_grant_a", rd_req_grants, 4'b0001);
    tick();
    axi.rvalid = 1'b1;
    rd_resp_grants = 4'b0001;
    #1;
    check("sc_grant_with_return", rd_req_grants, 4'b0001);
    tick();
    axi.rvalid = 1'b0;
    rd_resp_grants = '0;
    #1;
    check("sc_still_eligible", rd_req_grants, 4'b0001);
    tick();
    #1;
    check("sc_now_at_limit", rd_req_grants, 4'b0000);
    rd_reqs[0].valid = 1'b0;
    axi.rvalid = 1'b1;
    rd_resp_grants = 4'b0001;
    tick();
    tick();
    axi.rvalid = 1'b0;
    rd_resp_grants = '0;
    tick();
    check("sc_idle", idle, 1'b1);

    // ---- split write handshake ----
    do_reset();
    wr_reqs[0].valid = 1'b1;
    wr_reqs[0].addr  = 64'h4000;
    wr_reqs[0].data  = 512'h1111;
    #1;
    check("wr_grant0", wr_req_grants, 4'b0001);
    tick();
    wr_reqs[0].valid = 1'b0;
    wr_reqs[1].valid = 1'b1;
    wr_reqs[1].addr  = 64'h4040;
    wr_reqs[1].data  = 512'h2222;
    axi.awready = 1'b1;
    axi.wready  = 1'b0;
    #1;
    check("wr_awvalid", axi.awvalid, 1'b1);
    check("wr_wvalid", axi.wvalid, 1'b1);
    check("wr_awid", axi.awid, 3'd0);
    check("wr_awaddr", axi.awaddr, 64'h4000);
    check("wr_wdata", axi.wdata, 512'h1111);
    check("wr_no_grant_a", wr_req_grants, 4'b0000);
    tick();
    #1;
    check("wr_aw_dropped", axi.awvalid, 1'b0);
    check("wr_w_held_a", axi.wvalid, 1'b1);
    check("wr_no_grant_b", wr_req_grants, 4'b0000);
    tick();
    #1;
    check("wr_w_held_b", axi.wvalid, 1'b1);
    check("wr_no_grant_c", wr_req_grants, 4'b0000);
    axi.wready = 1'b1;
    #1;
    check("wr_grant1", wr_req_grants, 4'b0010);
    tick();
    wr_reqs[1].valid = 1'b0;
    #1;
    check("wr2_awvalid", axi.awvalid, 1'b1);
    check("wr2_wvalid", axi.wvalid, 1'b1);
    check("wr2_awid", axi.awid, 3'd1);
    check("wr2_awaddr", axi.awaddr, 64'h4040);
    check("wr2_wdata", axi.wdata, 512'h2222);
    tick();
    #1;
    check("wr_done_aw", axi.awvalid, 1'b0);
    check("wr_done_w", axi.wvalid, 1'b0);
    check("wr_idle", idle, 1'b1);

    // ---- reset with three reads and a write in flight ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rd_reqs[i].valid = 1'b1;
      rd_reqs[i].addr  = 64'h5000 + 64'h40 * i;
    end
    wr_reqs[3].valid = 1'b1;
    axi.arready = 1'b1;
    tick();
    tick();
    tick();
    #1;
    check("mr_busy", idle, 1'b0);
    check("mr_aw_pending", axi.awvalid, 1'b1);
    rst = 1'b0;
    axi.rvalid = 1'b1;
    axi.rid    = 3'd1;
    rd_resp_grants = '1;
    #1;
    check("mr_rready_in_reset", axi.rready, 1'b0);
    check("mr_resp_in_reset", rd_resps[1].valid, 1'b0);
    check("mr_rd_grant_in_reset", rd_req_grants, 4'b0000);
    check("mr_wr_grant_in_reset", wr_req_grants, 4'b0000);
    tick();
    check("mr_arvalid", axi.arvalid, 1'b0);
    check("mr_awvalid", axi.awvalid, 1'b0);
    check("mr_wvalid", axi.wvalid, 1'b0);
    check("mr_idle", idle, 1'b1);
    clear_inputs();
    rst = 1'b1;
    tick();
    check("mr_idle_after", idle, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
